// File: rtl/roulette_wheel_spinner.sv
// Roulette result generator: a free-running Galois LFSR draws a target in 1..31,
// then the wheel steps with a lengthening period and stops on that target.
module roulette_wheel_spinner #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic [15:0] START_PERIOD = 16'd4,
    parameter logic [15:0] PERIOD_INC   = 16'd2,
    parameter logic [15:0] STOP_PERIOD  = 16'd40
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        spin_req,
    input  logic        result_ack,
    output logic [4:0]  randnum,
    output logic        randnum_valid,
    output logic        busy,
    output logic [4:0]  wheel_pos,
    output logic [7:0]  spin_count,
    output logic [1:0]  dbg_state_o,
    output logic [15:0] dbg_lfsr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        SPIN = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [4:0]  target_q;
    logic [15:0] period_q;
    logic [15:0] period_d;
    logic [15:0] cnt_q;
    logic [4:0]  wheel_pos_q;
    logic [4:0]  wheel_pos_d;
    logic [4:0]  randnum_q;
    logic        randnum_valid_q;
    logic        busy_q;
    logic [7:0]  spin_count_q;
    logic [16:0] period_sum;
    logic        step;

    always_comb begin
        // An all-zero LFSR would lock up, so it is reseeded instead of shifted.
        if (lfsr_q == 16'd0) begin
            lfsr_d = SEED;
        end else begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
        wheel_pos_d = (wheel_pos_q == 5'd31) ? 5'd1 : wheel_pos_q + 5'd1;
        period_sum  = {1'b0, period_q} + {1'b0, PERIOD_INC};
        period_d    = period_sum[16] ? 16'hFFFF : period_sum[15:0];
        step        = (cnt_q == period_q - 16'd1);
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            lfsr_q          <= SEED;
            target_q        <= 5'd1;
            period_q        <= START_PERIOD;
            cnt_q           <= 16'd0;
            wheel_pos_q     <= 5'd1;
            randnum_q       <= 5'd0;
            randnum_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            spin_count_q    <= 8'd0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: begin
                    if (spin_req) begin
                        state_q <= DRAW;
                        busy_q  <= 1'b1;
                    end
                end
                DRAW: begin
                    // A zero draw is rejected and retried so 1..31 stay equally likely.
                    if (lfsr_q[4:0] != 5'd0) begin
                        target_q <= lfsr_q[4:0];
                        period_q <= START_PERIOD;
                        cnt_q    <= 16'd0;
                        state_q  <= SPIN;
                    end
                end
                SPIN: begin
                    if (step) begin
                        cnt_q       <= 16'd0;
                        wheel_pos_q <= wheel_pos_d;
                        period_q    <= period_d;
                        if ((period_q >= STOP_PERIOD) && (wheel_pos_d == target_q)) begin
                            state_q         <= HOLD;
                            randnum_q       <= target_q;
                            randnum_valid_q <= 1'b1;
                            busy_q          <= 1'b0;
                            spin_count_q    <= spin_count_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                HOLD: begin
                    if (result_ack) begin
                        state_q         <= IDLE;
                        randnum_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign randnum       = randnum_q;
    assign randnum_valid = randnum_valid_q;
    assign busy          = busy_q;
    assign wheel_pos     = wheel_pos_q;
    assign spin_count    = spin_count_q;
    assign dbg_state_o   = state_q;
    assign dbg_lfsr_o    = lfsr_q;

endmodule

// File: tb/tb_roulette_wheel_spinner.sv
// Bench for roulette_wheel_spinner: a slow instance (2/1/5) for step timing and hold
// behaviour, and a fast instance (1/0/1) for the 256-spin counter wrap.
module tb_roulette_wheel_spinner;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int START_P [2] = '{2, 1};
    localparam int INC_P   [2] = '{1, 0};
    localparam int STOP_P  [2] = '{5, 1};
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd3;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        spin_req   [2];
    logic        result_ack [2];
    logic [4:0]  randnum_w  [2];
    logic        valid_w    [2];
    logic        busy_w     [2];
    logic [4:0]  wheel_w    [2];
    logic [7:0]  cnt_w      [2];
    logic [1:0]  st_w       [2];
    logic [15:0] lfsr_w     [2];

    roulette_wheel_spinner #(
        .SEED(SEED), .START_PERIOD(16'd2), .PERIOD_INC(16'd1), .STOP_PERIOD(16'd5)
    ) u_main (
        .Clock(clk), .reset(rst), .spin_req(spin_req[0]), .result_ack(result_ack[0]),
        .randnum(randnum_w[0]), .randnum_valid(valid_w[0]), .busy(busy_w[0]),
        .wheel_pos(wheel_w[0]), .spin_count(cnt_w[0]),
        .dbg_state_o(st_w[0]), .dbg_lfsr_o(lfsr_w[0])
    );

    roulette_wheel_spinner #(
        .SEED(SEED), .START_PERIOD(16'd1), .PERIOD_INC(16'd0), .STOP_PERIOD(16'd1)
    ) u_fast (
        .Clock(clk), .reset(rst), .spin_req(spin_req[1]), .result_ack(result_ack[1]),
        .randnum(randnum_w[1]), .randnum_valid(valid_w[1]), .busy(busy_w[1]),
        .wheel_pos(wheel_w[1]), .spin_count(cnt_w[1]),
        .dbg_state_o(st_w[1]), .dbg_lfsr_o(lfsr_w[1])
    );

    // reference model state
    logic [15:0] m_lfsr [2];
    logic [4:0]  m_pos  [2];
    logic [7:0]  m_cnt  [2];
    logic [4:0]  exp_q [$];
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        if (x == 16'd0) return SEED;
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr[0] <= SEED;
            m_lfsr[1] <= SEED;
        end else begin
            m_lfsr[0] <= lfsr_step(m_lfsr[0]);
            m_lfsr[1] <= lfsr_step(m_lfsr[1]);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s act=timeout exp=event", name);
    endtask

    task automatic run_spin(input int u, input int hold_cycles, input bit toggle_req,
                            input bit ack_with_req, output int draws);
        logic [4:0] t;
        logic [4:0] p;
        logic [4:0] rn_exp;
        int per;
        int guard;
        bit landed;
        draws = 0;
        spin_req[u] = 1'b1;
        tick();
        spin_req[u] = 1'b0;
        chk("busy_after_req", busy_w[u], 1);
        chk("state_draw", st_w[u], S_DRAW);
        t = 5'd0;
        guard = 0;
        while (t == 5'd0 && guard < 64) begin
            t = m_lfsr[u][4:0];
            tick();
            draws++;
            guard++;
            if (t == 5'd0) chk("redraw_state", st_w[u], S_DRAW);
        end
        if (t == 5'd0) begin
            fail_now("draw_bound");
            return;
        end
        exp_q.push_back(t);
        p = m_pos[u];
        per = START_P[u];
        landed = 1'b0;
        guard = 0;
        while (!landed && guard < 20000) begin
            for (int c = 1; c < per; c++) begin
                tick();
                guard++;
                chk("pos_between_steps", wheel_w[u], p);
            end
            tick();
            guard++;
            p = (p == 5'd31) ? 5'd1 : p + 5'd1;
            chk("pos_on_step", wheel_w[u], p);
            if (per >= STOP_P[u] && p == t) begin
                landed = 1'b1;
            end else begin
                chk("no_valid_in_spin", valid_w[u], 0);
                chk("busy_in_spin", busy_w[u], 1);
                per = (per + INC_P[u] > 65535) ? 65535 : per + INC_P[u];
            end
        end
        if (!landed) begin
            fail_now("spin_bound");
            return;
        end
        m_pos[u] = p;
        m_cnt[u] = m_cnt[u] + 8'd1;
        rn_exp = exp_q.pop_front();
        chk("valid_on_land", valid_w[u], 1);
        chk("busy_on_land", busy_w[u], 0);
        chk("randnum", randnum_w[u], rn_exp);
        chk("randnum_range", (randnum_w[u] >= 5'd1) && (randnum_w[u] <= 5'd31), 1);
        chk("spin_count", cnt_w[u], m_cnt[u]);
        for (int h = 0; h < hold_cycles; h++) begin
            if (toggle_req) spin_req[u] = ~spin_req[u];
            tick();
            chk("hold_valid", valid_w[u], 1);
            chk("hold_randnum", randnum_w[u], rn_exp);
            chk("hold_state", st_w[u], S_HOLD);
            chk("hold_busy", busy_w[u], 0);
        end
        spin_req[u] = ack_with_req;
        result_ack[u] = 1'b1;
        tick();
        result_ack[u] = 1'b0;
        spin_req[u] = 1'b0;
        chk("valid_after_ack", valid_w[u], 0);
        chk("idle_after_ack", st_w[u], S_IDLE);
        chk("randnum_kept", randnum_w[u], rn_exp);
        if (ack_with_req) begin
            tick();
            chk("ack_req_no_spin", st_w[u], S_IDLE);
            chk("ack_req_no_busy", busy_w[u], 0);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       req;
        logic       ack;
        int         cycles;
        logic       busy;
        logic       valid;
        logic [4:0] pos;
        logic [4:0] rn;
        logic [7:0] cnt;
        logic [1:0] st;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #20_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        bit seen;
        logic [15:0] nxt;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2,   1'b0, 1'b0, 5'd1, 5'd0, 8'd0, S_IDLE};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0, 5'd1, 5'd0, 8'd0, S_IDLE};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5,   1'b0, 1'b0, 5'd1, 5'd0, 8'd0, S_IDLE};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1,   1'b1, 1'b0, 5'd1, 5'd0, 8'd0, S_DRAW};
        for (int i = 0; i < 2; i++) begin
            spin_req[i] = 1'b0;
            result_ack[i] = 1'b0;
            m_pos[i] = 5'd1;
            m_cnt[i] = 8'd0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_lfsr", lfsr_w[0], 16'hACE1);

        for (int i = 0; i < 4; i++) begin
            rst = vecs[i].rst;
            spin_req[0] = vecs[i].req;
            result_ack[0] = vecs[i].ack;
            repeat (vecs[i].cycles) tick();
            chk("vec_busy", busy_w[0], vecs[i].busy);
            chk("vec_valid", valid_w[0], vecs[i].valid);
            chk("vec_pos", wheel_w[0], vecs[i].pos);
            chk("vec_randnum", randnum_w[0], vecs[i].rn);
            chk("vec_count", cnt_w[0], vecs[i].cnt);
            chk("vec_state", st_w[0], vecs[i].st);
            if (i == 1) chk("lfsr_vs_model", lfsr_w[0], m_lfsr[0]);
        end
        spin_req[0] = 1'b0;
        result_ack[0] = 1'b0;

        // reset in the middle of a spin abandons the round
        repeat (12) tick();
        chk("mid_spin_busy", busy_w[0], 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_pos", wheel_w[0], 1);
        chk("rst_mid_busy", busy_w[0], 0);
        chk("rst_mid_valid", valid_w[0], 0);
        chk("rst_mid_count", cnt_w[0], 0);
        chk("rst_mid_state", st_w[0], S_IDLE);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (valid_w[0] || busy_w[0]) seen = 1'b1;
        end
        chk("no_result_after_reset", seen, 0);

        // first full spin, then a forced zero draw, then a long hold with spin_req noise
        run_spin(0, 1, 1'b0, 1'b0, d);
        chk("first_spin_count", cnt_w[0], 1);

        nxt = lfsr_step(m_lfsr[0]);
        d = 0;
        while (nxt[4:0] != 5'd0 && d < 4000) begin
            tick();
            nxt = lfsr_step(m_lfsr[0]);
            d++;
        end
        if (nxt[4:0] != 5'd0) begin
            fail_now("zero_draw_search");
        end else begin
            run_spin(0, 1, 1'b0, 1'b0, d);
            chk("zero_draw_rejected", d >= 2, 1);
        end

        run_spin(0, 50, 1'b1, 1'b1, d);

        // 256 back-to-back spins on the fast wheel wrap the counter
        chk("fast_count_start", cnt_w[1], 0);
        for (int s = 0; s < 256; s++) run_spin(1, 1, 1'b0, 1'b0, d);
        chk("count_wrap", cnt_w[1], 0);
        chk("fast_pos_nonzero", wheel_w[1] != 5'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
